uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Oversampling UART receive front-end that sits directly downstream of the baud divider and feeds received bytes to the UART core/register side. It synchronises the asynchronous `rxd` pin, detects start bits, samples each bit at mid-bit using a 16x baud enable, and assembles 8N1 frames. Each completed byte is held in a one-deep output register with a valid/read handshake, plus framing-error and overrun reporting.

## Interface
- `OVERSAMPLE`, 16, tick enables per bit period (power of two, ≥8)
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `tick`  in  1  one-`clk` enable at OVERSAMPLE x baud, from the baud divider
- `rxd`  in  1  asynchronous serial input, idle high
- `rd`  in  1  one-`clk` pulse: consumer has taken `data_o`
- `data_o`  out  8  last correctly framed byte, LSB received first
- `rx_valid`  out  1  level; byte in `data_o` not yet read
- `frame_err`  out  1  one-`clk` pulse; stop bit sampled low
- `overrun`  out  1  sticky; byte completed while `rx_valid` already high
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Synchroniser: two flops, both reset to 1; `rxs` = second flop output. All decisions use `rxs`, and only on cycles with `tick`=1.
- Bit counter `cnt` has width log2(OVERSAMPLE); bit index `idx` is 3 bits; shift register `sh` is 8 bits.
- IDLE: on tick with `rxs`=0, set `cnt`=0 and go to START.
- START: on tick, if `cnt`==OVERSAMPLE/2−1, check `rxs`:
  - `rxs`=0: `cnt`=0, `idx`=0, go to DATA.
  - `rxs`=1: false start (glitch); return to IDLE with no output.
  - Otherwise `cnt`++.
- DATA: on tick, if `cnt`==OVERSAMPLE−1: `sh` = {`rxs`, `sh`[7:1]}, `cnt`=0; if `idx`==7 go to STOP, else `idx`++. Otherwise `cnt`++.
- STOP: on tick with `cnt`==OVERSAMPLE−1, sample `rxs`:
  - `rxs`=1: `data_o`←`sh`, `rx_valid`←1; if `rx_valid` was already 1 and `rd`=0 this cycle, set `overrun`. Go to IDLE.
  - `rxs`=0: pulse `frame_err`; `data_o`/`rx_valid` unchanged; go to BREAK.
- BREAK: stay until a tick with `rxs`=1, then go to IDLE. Prevents a held-low line from being decoded as repeated 0x00 frames.
- `rd` clears `rx_valid` and `overrun`. `rd` while `rx_valid`=0 has no effect.
- Simultaneous `rd` and good-stop load: load wins; `rx_valid` stays 1, `overrun` is cleared (not set).
- `tick`=0 freezes all sampling state; synchroniser and handshake still run.

## Timing
- Reset values: state IDLE, `cnt`/`idx`/`sh`=0, `data_o`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0; synchroniser =1.
- Reset asserted mid-frame aborts immediately. After release, the block returns to IDLE and needs a fresh high-to-low transition plus start-bit validation.
- Input latency: `rxd` change visible in `rxs` after 2 `clk` edges.
- Sampling points, counted from the detection tick: start check at tick +OVERSAMPLE/2; data bit n at +OVERSAMPLE/2 + 16(n+1) (OVERSAMPLE=16); stop bit at +OVERSAMPLE/2 + 144.
- `rx_valid` rises, or `frame_err` pulses, on the `clk` edge of the stop-sample tick, i.e. registered one cycle after that tick is presented.
- A new start bit is accepted on the first tick after returning to IDLE, so back-to-back frames with exactly one stop bit are supported.

## Test plan
- `tick` tied 1, OVERSAMPLE=16, send 0xA5 at 16 clk/bit → `data_o`=0xA5, `rx_valid`=1 after 152 ticks from detection, `busy` low after.
- Low glitch of 4 ticks on idle line → no `rx_valid`, no `frame_err`, state back to IDLE by tick 8.
- Send 0x3C with stop bit 0, hold low 40 ticks, then high → `frame_err` single pulse, `data_o` keeps previous byte, no frame decoded during low hold.
- Back-to-back 0x11, 0x22, no `rd` → `data_o`=0x22, `rx_valid`=1, `overrun`=1; one `rd` pulse → both clear.
- `rd` on the same cycle as the 0x22 load → `rx_valid`=1, `overrun`=0, `data_o`=0x22.
- `rst` low mid-DATA of 0x55, release, send 0x0F → all outputs at reset values during reset; only 0x0F received.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receive front-end: synchronises rxd, validates the start bit,
// samples each bit at mid-period and hands bytes over through a one-deep valid/read register.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data_o,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic          sync1_q, sync2_q;
  logic          rxs;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic          load;

  assign rxs = sync2_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    load    = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            cnt_d   = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            if (!rxs) begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            sh_d  = {rxs, sh_q[7:1]};
            cnt_d = '0;
            if (idx_q == 3'd7) state_d = S_STOP;
            else               idx_d   = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxs) begin
              load    = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A held-low line parks here so it is not decoded as a stream of 0x00 frames.
        S_BREAK: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Read acknowledges first; a coincident load then wins and keeps the byte valid.
    if (rd && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load) begin
      data_d  = sh_q;
      valid_d = 1'b1;
      if (valid_q && !rd) ovr_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o    = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed timing/handshake cases plus randomized frames,
// with a frame-level scoreboard checked by an independent monitor.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data_o;
  logic       rx_valid, frame_err, overrun, busy;

  int checks = 0;
  int failures = 0;
  int tick_period = 1;
  bit auto_rd = 1'b0;
  int fe_count = 0;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  uart_rx_sampler #(.OVERSAMPLE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .rxd      (rxd),
    .rd       (rd),
    .data_o   (data_o),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    step(16 * tick_period);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit push);
    if (push) sb_q.push_back('{1'b0, b});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
  endtask

  // Stop bit sampled low, line held low for extra ticks, then released.
  task automatic send_bad(input logic [7:0] b, input int low_ticks);
    sb_q.push_back('{1'b1, 8'h00});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rxd = 1'b0;
    step((16 + low_ticks) * tick_period);
    rxd = 1'b1;
    step(4 * tick_period);
  endtask

  task automatic read_pulse();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  data_o,    32'h0);
    check({tag, "_valid"}, rx_valid,  32'h0);
    check({tag, "_ferr"},  frame_err, 32'h0);
    check({tag, "_ovr"},   overrun,   32'h0);
    check({tag, "_busy"},  busy,      32'h0);
  endtask

  task automatic sb_event(input bit is_ferr);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: event ferr=%0d data=%0h but none expected at %0t",
               is_ferr, data_o, $time);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", is_ferr, e.is_ferr);
      if (!is_ferr) begin
        check("sb_data", data_o, e.data);
        check("sb_ovr", overrun, 32'h0);
      end
    end
  endtask

  // Tick generator: one-cycle pulse every tick_period clocks.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      if (ph >= tick_period) ph = 0;
      tick = (ph == 0);
    end
  end

  // Monitor: every new byte or framing error is matched against the scoreboard.
  initial begin
    bit prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) begin
        fe_count++;
        sb_event(1'b1);
      end
      if (rx_valid && !prev_valid) sb_event(1'b0);
      prev_valid = rx_valid;
    end
  end

  // Consumer: reads a valid byte after a short random delay when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_rd && rx_valid) begin
        step($urandom_range(1, 8));
        read_pulse();
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int fe0;
    rst = 1'b0;
    step(5);
    check_reset_values("rst");
    rst = 1'b1;
    step(10);

    // Single frame with exact latency from the falling edge on rxd.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        step(154);
        check("a5_pre_valid", rx_valid, 32'h0);
        check("a5_pre_busy",  busy,     32'h1);
        step(1);
        check("a5_valid", rx_valid, 32'h1);
        check("a5_data",  data_o,   32'hA5);
        check("a5_busy",  busy,     32'h0);
        check("a5_ovr",   overrun,  32'h0);
      end
    join
    read_pulse();
    check("a5_read_clears", rx_valid, 32'h0);

    // Short low glitch: start validation rejects it.
    step(20);
    rxd = 1'b0;
    step(4);
    rxd = 1'b1;
    step(6);
    check("glitch_busy_mid", busy, 32'h1);
    step(1);
    check("glitch_idle", busy, 32'h0);
    step(20);
    check("glitch_no_valid", rx_valid, 32'h0);

    // Back-to-back without reads produces overrun.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    step(5);
    check("ovr_data",  data_o,   32'h22);
    check("ovr_valid", rx_valid, 32'h1);
    check("ovr_flag",  overrun,  32'h1);
    read_pulse();
    check("ovr_rd_valid", rx_valid, 32'h0);
    check("ovr_rd_flag",  overrun,  32'h0);
    read_pulse();
    check("idle_rd_valid", rx_valid, 32'h0);
    check("idle_rd_data",  data_o,   32'h22);

    // Read coinciding with the load: load wins, no overrun.
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b0);
      begin
        step(154);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
      end
    join
    check("sim_valid", rx_valid, 32'h1);
    check("sim_ovr",   overrun,  32'h0);
    check("sim_data",  data_o,   32'h22);
    read_pulse();

    // Framing error followed by a held-low break.
    step(20);
    fe0 = fe_count;
    sb_q.push_back('{1'b1, 8'h00});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h3C >> i);
    rxd = 1'b0;
    step(16 + 40);
    check("brk_busy",   busy,           32'h1);
    check("brk_pulses", fe_count - fe0, 32'h1);
    check("brk_valid",  rx_valid,       32'h0);
    rxd = 1'b1;
    step(4);
    check("brk_idle",   busy,           32'h0);
    check("brk_data",   data_o,         32'h22);
    check("brk_ferr",   frame_err,      32'h0);

    // Reset in the middle of a frame, then a clean frame.
    send_frame(8'h77, 1'b1);
    step(5);
    check("pre_rst_valid", rx_valid, 32'h1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b0;
    rxd = 1'b1;
    step(2);
    check_reset_values("midrst");
    rst = 1'b1;
    step(20);
    check("post_rst_busy", busy, 32'h0);
    send_frame(8'h0F, 1'b1);
    step(5);
    check("post_rst_data",  data_o,   32'h0F);
    check("post_rst_valid", rx_valid, 32'h1);
    read_pulse();

    // Randomized frames at several tick rates with an automatic consumer.
    auto_rd = 1'b1;
    for (int n = 0; n < 24; n++) begin
      tick_period = $urandom_range(1, 3);
      step($urandom_range(2, 30));
      if ($urandom_range(0, 99) < 15) send_bad(8'($urandom), $urandom_range(0, 30));
      else                            send_frame(8'($urandom), 1'b1);
    end
    step(200);
    check("sb_drained", sb_q.size(), 32'h0);
    check("rand_ovr",   overrun,     32'h0);
    check("rand_idle",  busy,        32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
